// File: rtl/decode_issue_stage.sv
// Decode/issue stage: buffers fetched instructions in a circular queue, decodes the head and
// issues it over valid/ready. A per-register scoreboard stalls the head on RAW hazards.
module decode_issue_stage #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned REG_BASE = 0,
   parameter int unsigned QDEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [6:0]        out_opcode,
   output logic [2:0]        out_funct3,
   output logic [6:0]        out_funct7,
   output logic [XLEN-8:0]   out_imm_raw,
   output logic [ADDR_W-1:0] out_rs1_A,
   output logic [ADDR_W-1:0] out_rs2_A,
   output logic [ADDR_W-1:0] out_rd_A,
   output logic              out_rd_we,
   output logic              out_illegal,
   output logic [XLEN-1:0]   out_pc,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd
);

   localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [ADDR_W-1:0] BaseA = ADDR_W'(REG_BASE);

   function automatic logic op_writes_rd(input logic [6:0] op);
      case (op)
         7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: return 1'b1;
         default:                                         return 1'b0;
      endcase
   endfunction

   function automatic logic op_uses_rs1(input logic [6:0] op);
      case (op)
         7'h67, 7'h03, 7'h13, 7'h33, 7'h23, 7'h63: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

   function automatic logic op_uses_rs2(input logic [6:0] op);
      case (op)
         7'h33, 7'h23, 7'h63: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   function automatic logic op_legal(input logic [6:0] op);
      return op_writes_rd(op) | op_uses_rs1(op) | op_uses_rs2(op) | (op == 7'h0F) | (op == 7'h73);
   endfunction

   logic [XLEN-1:0]   instr_mem_q [QDEPTH];
   logic [XLEN-1:0]   pc_mem_q    [QDEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [31:0]       pending_q, pending_d;

   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_instr_q, out_pc_q;
   logic [ADDR_W-1:0] out_rs1_a_q, out_rs2_a_q, out_rd_a_q;
   logic              out_rd_we_q, out_illegal_q;

   logic [XLEN-1:0]   head_instr, head_pc;
   logic [6:0]        head_op;
   logic [4:0]        head_rs1, head_rs2, head_rd, out_rd_idx;
   logic              head_valid, busy_rs1, busy_rs2, hazard;
   logic              push, issue, out_hs;

   assign head_instr = instr_mem_q[rd_ptr_q];
   assign head_pc    = pc_mem_q[rd_ptr_q];
   assign head_op    = head_instr[6:0];
   assign head_rd    = head_instr[11:7];
   assign head_rs1   = head_instr[19:15];
   assign head_rs2   = head_instr[24:20];
   assign head_valid = (count_q != '0);
   assign out_rd_idx = out_instr_q[11:7];

   // The instruction sitting in the output register has not reached the scoreboard yet.
   always_comb begin
      busy_rs1 = (head_rs1 != 5'd0) &&
                 (pending_q[head_rs1] || (out_valid_q && out_rd_we_q && out_rd_idx == head_rs1));
      busy_rs2 = (head_rs2 != 5'd0) &&
                 (pending_q[head_rs2] || (out_valid_q && out_rd_we_q && out_rd_idx == head_rs2));
      hazard   = (op_uses_rs1(head_op) && busy_rs1) || (op_uses_rs2(head_op) && busy_rs2);
   end

   assign in_ready = !rst && (count_q < CntW'(QDEPTH));
   assign push     = in_valid && in_ready && !flush;
   assign out_hs   = out_valid_q && out_ready;
   assign issue    = !flush && head_valid && !hazard && (!out_valid_q || out_ready);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CntW'(push) - CntW'(issue);
         if (issue) out_valid_d = 1'b1;
         else if (out_hs) out_valid_d = 1'b0;
      end
   end

   // Clear first so a same-index set wins.
   always_comb begin
      pending_d = pending_q;
      if (wb_valid) pending_d[wb_rd] = 1'b0;
      if (out_hs && out_rd_we_q && !flush) pending_d[out_rd_idx] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= in_instr;
         pc_mem_q[wr_ptr_q]    <= in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         pending_q     <= '0;
         out_valid_q   <= 1'b0;
         out_instr_q   <= '0;
         out_pc_q      <= '0;
         out_rs1_a_q   <= '0;
         out_rs2_a_q   <= '0;
         out_rd_a_q    <= '0;
         out_rd_we_q   <= 1'b0;
         out_illegal_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         if (issue) begin
            out_instr_q   <= head_instr;
            out_pc_q      <= head_pc;
            out_rs1_a_q   <= BaseA + ADDR_W'(head_rs1);
            out_rs2_a_q   <= BaseA + ADDR_W'(head_rs2);
            out_rd_a_q    <= BaseA + ADDR_W'(head_rd);
            out_rd_we_q   <= op_writes_rd(head_op) && (head_rd != 5'd0);
            out_illegal_q <= !op_legal(head_op);
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_opcode  = out_instr_q[6:0];
   assign out_funct3  = out_instr_q[14:12];
   assign out_funct7  = out_instr_q[31:25];
   assign out_imm_raw = out_instr_q[XLEN-1:7];
   assign out_rs1_A   = out_rs1_a_q;
   assign out_rs2_A   = out_rs2_a_q;
   assign out_rd_A    = out_rd_a_q;
   assign out_rd_we   = out_rd_we_q;
   assign out_illegal = out_illegal_q;
   assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios followed by random traffic, each cycle
// compared against a queue-based reference model of the stage.
module tb_decode_issue_stage;

   localparam int          XLEN     = 32;
   localparam int          ADDR_W   = 16;
   localparam int unsigned REG_BASE = 32'hFFF0;
   localparam int          QDEPTH   = 4;

   logic              clk = 1'b0;
   logic              rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [XLEN-1:0]   in_instr, in_pc, out_pc;
   logic [6:0]        out_opcode, out_funct7;
   logic [2:0]        out_funct3;
   logic [XLEN-8:0]   out_imm_raw;
   logic [ADDR_W-1:0] out_rs1_A, out_rs2_A, out_rd_A;
   logic              out_rd_we, out_illegal, wb_valid;
   logic [4:0]        wb_rd;

   always #5 clk = ~clk;

   decode_issue_stage #(
      .XLEN(XLEN), .ADDR_W(ADDR_W), .REG_BASE(REG_BASE), .QDEPTH(QDEPTH)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_imm_raw(out_imm_raw), .out_rs1_A(out_rs1_A), .out_rs2_A(out_rs2_A),
      .out_rd_A(out_rd_A), .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_pc(out_pc),
      .wb_valid(wb_valid), .wb_rd(wb_rd)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } item_t;

   item_t       mq[$];
   bit          m_ov;
   logic [31:0] m_instr, m_pc;
   bit          m_rd_we, m_illegal;
   bit          m_pend[32];
   int          n_vec = 0;
   int          n_err = 0;

   function automatic bit f_writes(logic [6:0] op);
      return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
   endfunction
   function automatic bit f_rs1(logic [6:0] op);
      return op inside {7'h67, 7'h03, 7'h13, 7'h33, 7'h23, 7'h63};
   endfunction
   function automatic bit f_rs2(logic [6:0] op);
      return op inside {7'h33, 7'h23, 7'h63};
   endfunction
   function automatic bit f_legal(logic [6:0] op);
      return f_writes(op) || f_rs1(op) || f_rs2(op) || op == 7'h0F || op == 7'h73;
   endfunction
   function automatic logic [15:0] addr_of(int unsigned idx);
      return 16'((REG_BASE + idx) % 65536);
   endfunction

   function automatic bit reg_busy(logic [4:0] r);
      return (r != 0) && (m_pend[r] || (m_ov && m_rd_we && m_instr[11:7] == r));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge: advance the model on the current inputs, then compare every output.
   task automatic step();
      bit    hs, push, can_issue;
      item_t h;
      if (rst) begin
         mq.delete();
         m_ov = 0; m_instr = '0; m_pc = '0; m_rd_we = 0; m_illegal = 0;
         foreach (m_pend[i]) m_pend[i] = 0;
      end else begin
         hs        = m_ov && out_ready;
         push      = in_valid && (mq.size() < QDEPTH) && !flush;
         can_issue = 0;
         if (!flush && mq.size() > 0 && (!m_ov || out_ready)) begin
            h = mq[0];
            can_issue = !((f_rs1(h.instr[6:0]) && reg_busy(h.instr[19:15])) ||
                          (f_rs2(h.instr[6:0]) && reg_busy(h.instr[24:20])));
         end
         if (wb_valid) m_pend[wb_rd] = 0;
         if (hs && m_rd_we && !flush) m_pend[m_instr[11:7]] = 1;
         m_pend[0] = 0;
         if (flush) begin
            mq.delete();
            m_ov = 0;
         end else begin
            if (can_issue) begin
               void'(mq.pop_front());
               m_ov      = 1;
               m_instr   = h.instr;
               m_pc      = h.pc;
               m_illegal = !f_legal(h.instr[6:0]);
               m_rd_we   = f_writes(h.instr[6:0]) && h.instr[11:7] != 0;
            end else if (hs) begin
               m_ov = 0;
            end
            if (push) mq.push_back('{in_instr, in_pc});
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("in_ready", 64'(in_ready), 64'(!rst && mq.size() < QDEPTH));
      chk("out_pc", 64'(out_pc), 64'(m_pc));
      chk("out_opcode", 64'(out_opcode), 64'(m_instr[6:0]));
      chk("out_funct3", 64'(out_funct3), 64'(m_instr[14:12]));
      chk("out_funct7", 64'(out_funct7), 64'(m_instr[31:25]));
      chk("out_imm_raw", 64'(out_imm_raw), 64'(m_instr[31:7]));
      chk("out_rd_we", 64'(out_rd_we), 64'(m_rd_we));
      chk("out_illegal", 64'(out_illegal), 64'(m_illegal));
      if (m_instr == '0 && m_pc == '0 && !m_ov && !m_rd_we) begin
         chk("out_rs1_A", 64'(out_rs1_A), 64'(0));
         chk("out_rd_A", 64'(out_rd_A), 64'(0));
      end else begin
         chk("out_rs1_A", 64'(out_rs1_A), 64'(addr_of(m_instr[19:15])));
         chk("out_rs2_A", 64'(out_rs2_A), 64'(addr_of(m_instr[24:20])));
         chk("out_rd_A", 64'(out_rd_A), 64'(addr_of(m_instr[11:7])));
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ordy, input bit fl, input bit wbv, input logic [4:0] wbr);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      wb_valid  = wbv;
      wb_rd     = wbr;
      step();
   endtask

   logic [6:0] ops [12];
   logic [4:0] regs [5];
   logic [4:0] wbregs [8];

   initial begin
      logic [31:0] ins;
      ops    = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h23, 7'h63, 7'h0F, 7'h73, 7'h7F};
      regs   = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
      wbregs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31};

      rst = 1;
      drive(0, '0, '0, 1, 0, 0, 0);
      drive(0, '0, '0, 1, 0, 0, 0);
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      rst = 0;
      drive(0, '0, '0, 1, 0, 0, 0);
      chk("post_rst_in_ready", 64'(in_ready), 64'(1));

      // ADDI x5,x0,1 reaches the output one edge after the push
      drive(1, 32'h0010_0293, 32'h100, 1, 0, 0, 0);
      chk("addi_not_yet", 64'(out_valid), 64'(0));
      drive(0, '0, '0, 1, 0, 0, 0);
      chk("addi_valid", 64'(out_valid), 64'(1));
      chk("addi_opcode", 64'(out_opcode), 64'(7'b0010011));
      chk("addi_rd_A", 64'(out_rd_A), 64'(16'hFFF5));
      chk("addi_rs1_A", 64'(out_rs1_A), 64'(16'hFFF0));
      chk("addi_rd_we", 64'(out_rd_we), 64'(1));
      chk("addi_pc", 64'(out_pc), 64'(32'h100));

      // ADD x6,x5,x5 held until x5 writes back
      drive(1, 32'h0052_8333, 32'h104, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, '0, '0, 1, 0, 0, 0);
      chk("add_held", 64'(out_valid), 64'(0));
      drive(0, '0, '0, 1, 0, 1, 5'd5);
      chk("add_wb_edge", 64'(out_valid), 64'(0));
      drive(0, '0, '0, 1, 0, 0, 0);
      chk("add_issued", 64'(out_valid), 64'(1));
      chk("add_rd_A", 64'(out_rd_A), 64'(16'hFFF6));
      drive(0, '0, '0, 1, 0, 1, 5'd6);

      // Backpressure: fill the queue, then drain in order
      for (int i = 0; i < 7; i++)
         drive(1, 32'((i << 20) | (((i % 4) + 1) << 7) | 32'h13), 32'(32'h200 + 4 * i), 0, 0, 0, 0);
      chk("full_in_ready", 64'(in_ready), 64'(0));
      for (int i = 0; i < 10; i++) drive(0, '0, '0, 1, 0, 0, 0);
      for (int r = 1; r <= 4; r++) drive(0, '0, '0, 1, 0, 1, 5'(r));

      // Flush with a valid output and three queued entries
      for (int i = 0; i < 4; i++)
         drive(1, 32'(((i + 1) << 7) | 32'h13), 32'(32'h300 + 4 * i), 0, 0, 0, 0);
      drive(1, 32'h0000_0393, 32'h3F0, 0, 1, 0, 0);
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      chk("flush_in_ready", 64'(in_ready), 64'(1));
      for (int i = 0; i < 4; i++) drive(0, '0, '0, 1, 0, 0, 0);
      chk("flush_nothing_issued", 64'(out_valid), 64'(0));

      // NOP writes no register, so a later x0 reader never stalls
      drive(1, 32'h0000_0013, 32'h400, 1, 0, 0, 0);
      drive(1, 32'h0000_03B3, 32'h404, 1, 0, 0, 0);
      chk("nop_rd_we", 64'(out_rd_we), 64'(0));
      drive(0, '0, '0, 1, 0, 0, 0);
      chk("x0_no_stall", 64'(out_valid), 64'(1));
      chk("x0_rd_A", 64'(out_rd_A), 64'(16'hFFF7));
      drive(0, '0, '0, 1, 0, 1, 5'd7);

      // Address wrap and illegal opcode
      drive(1, 32'h0000_0F93, 32'h500, 1, 0, 0, 0);
      drive(1, 32'h0000_007F, 32'h504, 1, 0, 0, 0);
      chk("wrap_rd_A", 64'(out_rd_A), 64'(16'h000F));
      drive(0, '0, '0, 1, 0, 0, 0);
      chk("illegal_flag", 64'(out_illegal), 64'(1));
      chk("illegal_rd_we", 64'(out_rd_we), 64'(0));
      drive(0, '0, '0, 1, 0, 1, 5'd31);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         ins        = $urandom;
         ins[6:0]   = ops[$urandom_range(0, 11)];
         ins[11:7]  = regs[$urandom_range(0, 4)];
         ins[19:15] = regs[$urandom_range(0, 4)];
         ins[24:20] = regs[$urandom_range(0, 4)];
         drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
               wbregs[$urandom_range(0, 7)]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
